// File: rtl/sprite_animator.sv
// Per-player animation sequencer: turns move/punch/kick/hit requests into the
// GPU frame index, stepping only on frame_tick so a sprite never changes mid-scan.
module sprite_animator #(
  parameter int unsigned TICKS_PER_STEP = 4
) (
  input  logic       VGA_CLK,
  input  logic       RESET_N,
  input  logic       frame_tick,
  input  logic       move,
  input  logic       punch_req,
  input  logic       kick_req,
  input  logic       hit_req,
  output logic [9:0] animation,
  output logic [2:0] anim_state,
  output logic       attack_active,
  output logic       busy
);

  localparam int unsigned TW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(TICKS_PER_STEP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WALK  = 3'd1,
    S_PUNCH = 3'd2,
    S_KICK  = 3'd3,
    S_HURT  = 3'd4
  } state_t;

  state_t          r_state;
  logic [1:0]      r_step;
  logic [TW-1:0]   r_tcnt;
  logic            r_p_punch;
  logic            r_p_kick;
  logic            r_p_hit;

  state_t          w_nstate;
  logic [1:0]      w_nstep;
  logic [TW-1:0]   w_ntcnt;
  logic [1:0]      w_adv_step;
  logic [TW-1:0]   w_adv_tcnt;
  logic            w_tcnt_last;
  logic            w_punch;
  logic            w_kick;
  logic            w_hit;
  logic            w_enter;
  logic [3:0]      w_base;
  logic [1:0]      w_last_step;

  // A request coinciding with the tick takes part in that tick's decision.
  assign w_punch     = r_p_punch | punch_req;
  assign w_kick      = r_p_kick  | kick_req;
  assign w_hit       = r_p_hit   | hit_req;
  assign w_tcnt_last = (r_tcnt == TCNT_LAST);

  // Counter advance; the 2-bit step wraps 3->0 on its own for WALK.
  always_comb begin
    w_adv_step = r_step;
    w_adv_tcnt = r_tcnt + TW'(1);
    if (w_tcnt_last) begin
      w_adv_tcnt = '0;
      w_adv_step = r_step + 2'd1;
    end
  end

  always_comb begin
    w_last_step = 2'd0;
    case (r_state)
      S_PUNCH, S_KICK: w_last_step = 2'd2;
      S_HURT:          w_last_step = 2'd1;
      S_WALK:          w_last_step = 2'd3;
      default:         w_last_step = 2'd0;
    endcase
  end

  // Tick decision: hit first, then attacks, then walk/idle transitions.
  always_comb begin
    w_nstate = r_state;
    w_nstep  = r_step;
    w_ntcnt  = r_tcnt;
    w_enter  = 1'b0;
    if (frame_tick) begin
      if (w_hit && (r_state != S_HURT)) begin
        w_nstate = S_HURT;
        w_enter  = 1'b1;
      end else begin
        case (r_state)
          S_IDLE, S_WALK: begin
            if (w_punch) begin
              w_nstate = S_PUNCH;
              w_enter  = 1'b1;
            end else if (w_kick) begin
              w_nstate = S_KICK;
              w_enter  = 1'b1;
            end else if ((r_state == S_IDLE) && move) begin
              w_nstate = S_WALK;
              w_enter  = 1'b1;
            end else if ((r_state == S_WALK) && !move) begin
              w_nstate = S_IDLE;
              w_enter  = 1'b1;
            end else if (r_state == S_WALK) begin
              w_nstep = w_adv_step;
              w_ntcnt = w_adv_tcnt;
            end
          end
          S_PUNCH, S_KICK, S_HURT: begin
            if (w_tcnt_last && (r_step == w_last_step)) begin
              w_nstate = S_IDLE;
              w_enter  = 1'b1;
            end else begin
              w_nstep = w_adv_step;
              w_ntcnt = w_adv_tcnt;
            end
          end
          default: begin
            w_nstate = S_IDLE;
            w_enter  = 1'b1;
          end
        endcase
      end
      if (w_enter) begin
        w_nstep = 2'd0;
        w_ntcnt = '0;
      end
    end
  end

  always_comb begin
    w_base = 4'd0;
    case (w_nstate)
      S_WALK:  w_base = 4'd1;
      S_PUNCH: w_base = 4'd5;
      S_KICK:  w_base = 4'd8;
      S_HURT:  w_base = 4'd11;
      default: w_base = 4'd0;
    endcase
  end

  // State, pending flags and outputs all load together, so outputs track the state.
  always_ff @(posedge VGA_CLK) begin
    if (!RESET_N) begin
      r_state       <= S_IDLE;
      r_step        <= 2'd0;
      r_tcnt        <= '0;
      r_p_punch     <= 1'b0;
      r_p_kick      <= 1'b0;
      r_p_hit       <= 1'b0;
      animation     <= 10'd0;
      anim_state    <= 3'd0;
      attack_active <= 1'b0;
      busy          <= 1'b0;
    end else begin
      r_state       <= w_nstate;
      r_step        <= w_nstep;
      r_tcnt        <= w_ntcnt;
      r_p_punch     <= frame_tick ? 1'b0 : w_punch;
      r_p_kick      <= frame_tick ? 1'b0 : w_kick;
      r_p_hit       <= frame_tick ? 1'b0 : w_hit;
      animation     <= {6'd0, w_base + {2'b00, w_nstep}};
      anim_state    <= w_nstate;
      attack_active <= ((w_nstate == S_PUNCH) || (w_nstate == S_KICK)) && (w_nstep == 2'd1);
      busy          <= (w_nstate == S_PUNCH) || (w_nstate == S_KICK) || (w_nstate == S_HURT);
    end
  end

endmodule

// File: tb/tb_sprite_animator.sv
// Bench for sprite_animator: directed vector table, hand sequences for the
// multi-cycle cases, and random traffic against an elapsed-tick reference model.
module tb_sprite_animator;

  localparam int T = 4;

  logic       VGA_CLK;
  logic       RESET_N;
  logic       frame_tick;
  logic       move;
  logic       punch_req;
  logic       kick_req;
  logic       hit_req;
  logic [9:0] animation;
  logic [2:0] anim_state;
  logic       attack_active;
  logic       busy;

  sprite_animator #(.TICKS_PER_STEP(T)) dut (
    .VGA_CLK       (VGA_CLK),
    .RESET_N       (RESET_N),
    .frame_tick    (frame_tick),
    .move          (move),
    .punch_req     (punch_req),
    .kick_req      (kick_req),
    .hit_req       (hit_req),
    .animation     (animation),
    .anim_state    (anim_state),
    .attack_active (attack_active),
    .busy          (busy)
  );

  initial VGA_CLK = 1'b0;
  always #5 VGA_CLK = ~VGA_CLK;

  int n_vec = 0;
  int n_bad = 0;

  // Model: current action plus ticks elapsed since entering it.
  int base_of[5]  = '{0, 1, 5, 8, 11};
  int steps_of[5] = '{1, 4, 3, 3, 2};
  int m_state = 0;
  int m_e     = 0;
  bit m_pp = 0, m_pk = 0, m_ph = 0;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic model_step(input bit rst_n, input bit ft, input bit mv,
                            input bit p, input bit k, input bit h);
    bit ap, ak, ah;
    if (!rst_n) begin
      m_state = 0; m_e = 0; m_pp = 0; m_pk = 0; m_ph = 0;
      return;
    end
    ap = m_pp | p; ak = m_pk | k; ah = m_ph | h;
    if (!ft) begin
      m_pp = ap; m_pk = ak; m_ph = ah;
      return;
    end
    m_pp = 0; m_pk = 0; m_ph = 0;
    if (ah && m_state != 4) begin
      m_state = 4; m_e = 0;
    end else if (m_state <= 1) begin
      if (ap)                          begin m_state = 2; m_e = 0; end
      else if (ak)                     begin m_state = 3; m_e = 0; end
      else if (m_state == 0 && mv)     begin m_state = 1; m_e = 0; end
      else if (m_state == 1 && !mv)    begin m_state = 0; m_e = 0; end
      else if (m_state == 1)           m_e = (m_e + 1) % (4 * T);
    end else begin
      m_e++;
      if (m_e == steps_of[m_state] * T) begin
        m_state = 0; m_e = 0;
      end
    end
  endtask

  task automatic cmp_model();
    int step = m_e / T;
    check("model.animation", int'(animation), base_of[m_state] + step);
    check("model.anim_state", int'(anim_state), m_state);
    check("model.attack_active", int'(attack_active),
          ((m_state == 2 || m_state == 3) && step == 1) ? 1 : 0);
    check("model.busy", int'(busy), (m_state >= 2) ? 1 : 0);
  endtask

  // One clock: drive, advance model, sample #1 after the edge, compare.
  task automatic cyc(input bit rst_n, input bit ft, input bit mv,
                     input bit p, input bit k, input bit h);
    RESET_N = rst_n; frame_tick = ft; move = mv;
    punch_req = p; kick_req = k; hit_req = h;
    model_step(rst_n, ft, mv, p, k, h);
    @(posedge VGA_CLK);
    #1;
    cmp_model();
  endtask

  task automatic tick(input bit mv, input bit p, input bit k, input bit h);
    cyc(1, 0, mv, 0, 0, 0);
    cyc(1, 1, mv, p, k, h);
  endtask

  typedef struct {
    bit rst_n, ft, mv, p, k, h;
    int anim, st;
    bit att, bsy;
  } vec_t;

  function automatic vec_t mk(bit r, bit f, bit m, bit p, bit k, bit h,
                              int a, int s, bit at, bit b);
    vec_t v;
    v.rst_n = r; v.ft = f; v.mv = m; v.p = p; v.k = k; v.h = h;
    v.anim = a; v.st = s; v.att = at; v.bsy = b;
    return v;
  endfunction

  vec_t tbl[24];

  initial begin
    RESET_N = 0; frame_tick = 0; move = 0;
    punch_req = 0; kick_req = 0; hit_req = 0;

    // rst, ft, mv, p, k, h -> anim, state, att, busy
    tbl[0]  = mk(0, 1, 1, 1, 1, 1,  0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 1, 1,  0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 0, 1, 0,  0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[5]  = mk(1, 1, 0, 0, 1, 0,  8, 3, 0, 1);
    tbl[6]  = mk(1, 0, 0, 0, 0, 0,  8, 3, 0, 1);
    tbl[7]  = mk(1, 1, 0, 0, 0, 0,  8, 3, 0, 1);
    tbl[8]  = mk(1, 1, 0, 0, 0, 0,  8, 3, 0, 1);
    tbl[9]  = mk(1, 1, 0, 0, 0, 0,  8, 3, 0, 1);
    tbl[10] = mk(1, 1, 0, 0, 0, 0,  9, 3, 1, 1);
    tbl[11] = mk(1, 1, 0, 0, 0, 1, 11, 4, 0, 1);
    tbl[12] = mk(1, 1, 0, 0, 0, 1, 11, 4, 0, 1);
    tbl[13] = mk(1, 1, 0, 0, 0, 0, 11, 4, 0, 1);
    tbl[14] = mk(1, 1, 0, 0, 0, 0, 11, 4, 0, 1);
    tbl[15] = mk(1, 1, 0, 0, 0, 0, 12, 4, 0, 1);
    tbl[16] = mk(1, 1, 0, 0, 0, 0, 12, 4, 0, 1);
    tbl[17] = mk(1, 1, 0, 0, 0, 0, 12, 4, 0, 1);
    tbl[18] = mk(1, 1, 0, 0, 0, 0, 12, 4, 0, 1);
    tbl[19] = mk(1, 1, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[20] = mk(1, 0, 0, 0, 1, 0,  0, 0, 0, 0);
    tbl[21] = mk(1, 1, 0, 0, 0, 0,  8, 3, 0, 1);
    tbl[22] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[23] = mk(1, 1, 0, 0, 0, 0,  0, 0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      cyc(tbl[i].rst_n, tbl[i].ft, tbl[i].mv, tbl[i].p, tbl[i].k, tbl[i].h);
      check($sformatf("vec%0d.animation", i), int'(animation), tbl[i].anim);
      check($sformatf("vec%0d.anim_state", i), int'(anim_state), tbl[i].st);
      check($sformatf("vec%0d.attack_active", i), int'(attack_active), int'(tbl[i].att));
      check($sformatf("vec%0d.busy", i), int'(busy), int'(tbl[i].bsy));
    end

    // Walk cycle: 1,1,1,1,2,...,4,4,4,4,1 then idle once move drops.
    for (int i = 0; i < 17; i++) begin
      tick(1, 0, 0, 0);
      check($sformatf("walk%0d", i), int'(animation), 1 + (i / 4) % 4);
    end
    tick(0, 0, 0, 0);
    check("walk.stop", int'(animation), 0);

    // Punch with a second request issued mid-punch that must be ignored.
    cyc(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 13; i++) begin
      if (i == 6) cyc(1, 0, 0, 1, 0, 0);
      tick(0, 0, 0, 0);
      check($sformatf("punch%0d.anim", i), int'(animation), (i < 12) ? 5 + i / 4 : 0);
      check($sformatf("punch%0d.att", i), int'(attack_active), (i / 4 == 1) ? 1 : 0);
      check($sformatf("punch%0d.busy", i), int'(busy), (i < 12) ? 1 : 0);
    end

    // Punch beats kick; a hit at punch step 1 cuts straight to HURT.
    cyc(1, 0, 0, 1, 1, 0);
    tick(0, 0, 0, 0);
    check("prio.punch", int'(animation), 5);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
    check("prio.step1", int'(animation), 6);
    check("prio.att_on", int'(attack_active), 1);
    cyc(1, 1, 0, 0, 0, 1);
    check("prio.hurt", int'(animation), 11);
    check("prio.att_off", int'(attack_active), 0);
    for (int i = 1; i < 9; i++) begin
      tick(0, 0, 0, 0);
      check($sformatf("hurt%0d", i), int'(animation), (i < 4) ? 11 : (i < 8) ? 12 : 0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 59) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
